// File: rtl/calc_nport_rr.sv
// calc_nport_rr: NPORTS request ports sharing one WIDTH-bit ALU.
// Each lane captures a two-beat request, waits for a round-robin grant,
// then presents a one-cycle registered response.

// Per-port request FSM: capture cmd/op1, then op2, wait for grant, respond once.
module calc_nport_rr_lane #(
  parameter int WIDTH = 32
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic [3:0]       cmd_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             grant,
  input  logic [1:0]       alu_resp,
  input  logic [WIDTH-1:0] alu_data,
  output logic             pend,
  output logic             busy,
  output logic [3:0]       cmd,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [1:0]       resp,
  output logic [WIDTH-1:0] data
);
  typedef enum logic [1:0] {S_IDLE, S_OP2, S_PEND, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [1:0]       resp_q, resp_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next state; response outputs default to zero so they last one cycle only.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    resp_d  = '0;
    data_d  = '0;
    case (state_q)
      S_IDLE: if (cmd_in != 4'd0) begin
        state_d = S_OP2;
        cmd_d   = cmd_in;
        op1_d   = data_in;
      end
      S_OP2: begin
        op2_d   = data_in;
        state_d = S_PEND;
      end
      S_PEND: if (grant) begin
        state_d = S_RESP;
        resp_d  = alu_resp;
        data_d  = alu_data;
      end
      S_RESP: state_d = S_IDLE;
    endcase
  end

  // Lane state registers; reset discards any captured request.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      resp_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
    end
  end

  assign pend = (state_q == S_PEND);
  assign busy = (state_q != S_IDLE);
  assign cmd  = cmd_q;
  assign op1  = op1_q;
  assign op2  = op2_q;
  assign resp = resp_q;
  assign data = data_q;
endmodule

module calc_nport_rr #(
  parameter int NPORTS = 4,
  parameter int WIDTH  = 32,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic                      c_clk,
  input  logic                      reset,
  input  logic [NPORTS*4-1:0]       req_cmd_in,
  input  logic [NPORTS*WIDTH-1:0]   req_data_in,
  output logic [NPORTS*2-1:0]       out_resp,
  output logic [NPORTS*WIDTH-1:0]   out_data,
  output logic [NPORTS-1:0]         port_busy
);
  localparam int PW = $clog2(NPORTS);

  logic [NPORTS-1:0][3:0]       cmd_in, l_cmd;
  logic [NPORTS-1:0][WIDTH-1:0] data_in, l_op1, l_op2, l_data;
  logic [NPORTS-1:0][1:0]       l_resp;
  logic [NPORTS-1:0]            l_pend;
  logic [PW-1:0]                last_q, last_d, gnt_idx;
  logic                         gnt_vld;
  logic [3:0]                   a_cmd;
  logic [WIDTH-1:0]             a_op1, a_op2, alu_data;
  logic [1:0]                   alu_resp;
  logic [WIDTH:0]               sum;
  int                           idx;

  // Packed-array views of the flat port buses (port p in slice p).
  assign cmd_in   = req_cmd_in;
  assign data_in  = req_data_in;
  assign out_resp = l_resp;
  assign out_data = l_data;

  for (genvar i = 0; i < NPORTS; i++) begin : g_lane
    calc_nport_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .c_clk   (c_clk),
      .reset   (reset),
      .cmd_in  (cmd_in[i]),
      .data_in (data_in[i]),
      .grant   (gnt_vld && (gnt_idx == PW'(i))),
      .alu_resp(alu_resp),
      .alu_data(alu_data),
      .pend    (l_pend[i]),
      .busy    (port_busy[i]),
      .cmd     (l_cmd[i]),
      .op1     (l_op1[i]),
      .op2     (l_op2[i]),
      .resp    (l_resp[i]),
      .data    (l_data[i])
    );
  end

  // Round-robin search over pending ports starting just after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 1; i <= NPORTS; i++) begin
      idx = (int'(last_q) + i) % NPORTS;
      if (!gnt_vld && l_pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    last_d = gnt_vld ? gnt_idx : last_q;
  end

  // Pointer moves only on a grant; reset value gives port 0 first priority.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) last_q <= PW'(NPORTS - 1);
    else       last_q <= last_d;
  end

  assign a_cmd = l_cmd[gnt_idx];
  assign a_op1 = l_op1[gnt_idx];
  assign a_op2 = l_op2[gnt_idx];

  // Shared ALU for the granted port; errors return code 2 with zero data.
  always_comb begin
    alu_resp = 2'd2;
    alu_data = '0;
    sum      = {1'b0, a_op1} + {1'b0, a_op2};
    case (a_cmd)
      4'd1: if (!sum[WIDTH]) begin
        alu_resp = 2'd1;
        alu_data = sum[WIDTH-1:0];
      end
      4'd2: if (a_op2 <= a_op1) begin
        alu_resp = 2'd1;
        alu_data = a_op1 - a_op2;
      end
      4'd5: begin
        alu_resp = 2'd1;
        alu_data = a_op1 << a_op2[SHW-1:0];
      end
      4'd6: begin
        alu_resp = 2'd1;
        alu_data = a_op1 >> a_op2[SHW-1:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_calc_nport_rr.sv
// Bench for calc_nport_rr: timestamp-based reference model checked every
// negedge, plus directed cases with hand-computed literal expectations.
module tb_calc_nport_rr;
  localparam int NP = 4;
  localparam int W  = 32;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0][3:0]   cmd_v = '0;
  logic [NP-1:0][W-1:0] dat_v = '0;
  logic [NP*2-1:0]      out_resp;
  logic [NP*W-1:0]      out_data;
  logic [NP-1:0]        port_busy;

  int vectors = 0;
  int miscompares = 0;

  calc_nport_rr #(.NPORTS(NP), .WIDTH(W)) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (cmd_v),
    .req_data_in(dat_v),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .port_busy  (port_busy)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string nm, input logic [NP*W-1:0] act, input logic [NP*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic in 64-bit integers.
  function automatic void ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [1:0] r, output logic [W-1:0] d);
    longint unsigned la, lb, sh;
    la = a; lb = b; sh = lb % 32;
    r = 2'd2; d = '0;
    case (c)
      4'd1: if (la + lb < 64'h1_0000_0000) begin r = 2'd1; d = W'(la + lb); end
      4'd2: if (lb <= la) begin r = 2'd1; d = W'(la - lb); end
      4'd5: begin r = 2'd1; d = W'((la * (64'd1 << sh)) % 64'h1_0000_0000); end
      4'd6: begin r = 2'd1; d = W'(la / (64'd1 << sh)); end
      default: ;
    endcase
  endfunction

  // Model: each port records its acceptance cycle; eligible two cycles later.
  bit         m_busy[NP];
  bit         m_served[NP];
  int         m_acc[NP];
  int         m_rcyc[NP];
  logic [3:0] m_cmd[NP];
  logic [W-1:0] m_op1[NP];
  logic [W-1:0] m_op2[NP];
  logic [NP-1:0][1:0] e_resp = '0;
  logic [NP-1:0][W-1:0] e_data = '0;
  int m_last = NP - 1;
  int m_cyc = 0;
  int mg, mq;
  logic [1:0] mr;
  logic [W-1:0] md;

  initial begin
    for (int p = 0; p < NP; p++) begin
      m_busy[p] = 0; m_served[p] = 0; m_acc[p] = 0; m_rcyc[p] = 0;
      m_cmd[p] = '0; m_op1[p] = '0; m_op2[p] = '0;
    end
    forever begin
      @(posedge c_clk or posedge reset);
      if (reset) begin
        for (int p = 0; p < NP; p++) begin m_busy[p] = 0; m_served[p] = 0; end
        e_resp = '0; e_data = '0; m_last = NP - 1;
      end else begin
        mg = -1;
        for (int i = 1; i <= NP; i++) begin
          mq = (m_last + i) % NP;
          if (mg < 0 && m_busy[mq] && !m_served[mq] && m_cyc >= m_acc[mq] + 2) mg = mq;
        end
        e_resp = '0; e_data = '0;
        if (mg >= 0) begin
          ref_alu(m_cmd[mg], m_op1[mg], m_op2[mg], mr, md);
          e_resp[mg] = mr; e_data[mg] = md;
          m_served[mg] = 1; m_rcyc[mg] = m_cyc + 1; m_last = mg;
        end
        for (int p = 0; p < NP; p++) begin
          if (m_busy[p] && m_served[p] && m_rcyc[p] == m_cyc) m_busy[p] = 0;
          else if (!m_busy[p] && cmd_v[p] != 4'd0) begin
            m_busy[p] = 1; m_served[p] = 0; m_acc[p] = m_cyc;
            m_cmd[p] = cmd_v[p]; m_op1[p] = dat_v[p];
          end else if (m_busy[p] && m_cyc == m_acc[p] + 1) m_op2[p] = dat_v[p];
        end
      end
      m_cyc++;
    end
  end

  // Compare every cycle on the falling edge.
  logic [NP-1:0] e_busy;
  initial forever begin
    @(negedge c_clk);
    for (int p = 0; p < NP; p++) e_busy[p] = m_busy[p];
    chk("m_resp", out_resp, e_resp);
    chk("m_data", out_data, e_data);
    chk("m_busy", port_busy, e_busy);
  end

  task automatic tick();
    @(posedge c_clk); #1;
  endtask

  task automatic setp(input int p, input logic [3:0] c, input logic [W-1:0] d);
    cmd_v[p] = c; dat_v[p] = d;
  endtask

  // Uncontended request on port p; checks response at T+3 and clear at T+4.
  task automatic run1(input string nm, input int p, input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [1:0] er, input logic [W-1:0] ed);
    setp(p, c, a); tick();
    setp(p, 4'd0, b); tick();
    setp(p, 4'd0, '0); tick();
    chk({nm, "_resp"}, out_resp[2*p +: 2], er);
    chk({nm, "_data"}, out_data[W*p +: W], ed);
    tick();
    chk({nm, "_clr"}, {out_resp, out_data}, '0);
  endtask

  logic [7:0] er8;
  int r;

  initial begin
    tick(); tick();
    chk("rst_out", {out_resp, out_data}, '0);
    chk("rst_busy", port_busy, '0);
    reset = 1'b0;

    run1("add", 0, 4'd1, 32'h1, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000);
    run1("ovf", 0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0);
    run1("udf", 0, 4'd2, 32'd3, 32'd5, 2'd2, 32'h0);
    run1("sub0", 0, 4'd2, 32'd5, 32'd5, 2'd1, 32'h0);
    run1("shl", 0, 4'd5, 32'h1, 32'd33, 2'd1, 32'h2);
    run1("shr", 0, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h1);
    run1("inv", 0, 4'd3, 32'd1, 32'd2, 2'd2, 32'h0);
    run1("add_p3", 3, 4'd1, 32'd100, 32'd23, 2'd1, 32'd123);

    // Contention from a fresh pointer: ports served 0,1,2,3.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int p = 0; p < NP; p++) setp(p, 4'd1, W'(p + 1));
    tick();
    for (int p = 0; p < NP; p++) setp(p, 4'd0, W'(p + 1));
    tick();
    for (int p = 0; p < NP; p++) setp(p, 4'd0, '0);
    tick();
    for (int k = 0; k < NP; k++) begin
      er8 = 8'd1 << (2 * k);
      chk("cont_resp", out_resp, er8);
      chk("cont_data", out_data[W*k +: W], W'(2 * (k + 1)));
      tick();
    end
    setp(1, 4'd1, 32'd20); setp(0, 4'd1, 32'd10); tick();
    setp(1, 4'd0, 32'd1);  setp(0, 4'd0, 32'd2);  tick();
    setp(1, 4'd0, '0);     setp(0, 4'd0, '0);     tick();
    chk("wrap_p0", {out_resp, out_data[31:0]}, {8'h01, 32'd12});
    tick();
    chk("wrap_p1", {out_resp, out_data[63:32]}, {8'h04, 32'd21});
    tick();

    // Busy port ignores a new command.
    setp(2, 4'd1, 32'd7); tick();
    chk("busy_t1", port_busy[2], 1'b1);
    setp(2, 4'd0, 32'd1); tick();
    chk("busy_t2", port_busy[2], 1'b1);
    setp(2, 4'd2, 32'd0); tick();
    setp(2, 4'd0, 32'd0);
    chk("busy_resp", {out_resp, out_data[95:64], port_busy[2]}, {8'h10, 32'd8, 1'b1});
    tick();
    chk("busy_t4", {out_resp, port_busy}, '0);
    tick();
    chk("busy_none", out_resp, '0);

    // Async reset with a request pending.
    setp(1, 4'd1, 32'd40); tick();
    setp(1, 4'd0, 32'd2); tick();
    setp(1, 4'd0, '0);
    chk("ar_busy", port_busy[1], 1'b1);
    reset = 1'b1; #1;
    chk("ar_out", {out_resp, out_data, port_busy}, '0);
    tick(); reset = 1'b0;
    tick(); tick();
    chk("ar_none", out_resp, '0);
    run1("ar_fresh", 1, 4'd1, 32'd40, 32'd2, 2'd1, 32'd42);

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NP; p++) begin
        r = $urandom_range(0, 9);
        case (r)
          5: cmd_v[p] = 4'd1;
          6: cmd_v[p] = 4'd2;
          7: cmd_v[p] = 4'd5;
          8: cmd_v[p] = 4'd6;
          9: cmd_v[p] = 4'($urandom_range(3, 15));
          default: cmd_v[p] = 4'd0;
        endcase
        case ($urandom_range(0, 5))
          0: dat_v[p] = 32'h0;
          1: dat_v[p] = 32'hFFFF_FFFF;
          2: dat_v[p] = 32'h8000_0000;
          3: dat_v[p] = 32'($urandom_range(0, 40));
          default: dat_v[p] = $urandom;
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1; #2; reset = 1'b0;
      end
      tick();
    end
    cmd_v = '0; dat_v = '0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
